// File: rtl/avr_uart_tx.sv
// 8N1 UART transmitter toward an AVR receive pin, gated by the AVR's busy flag.
// Define AVR_UART_TX_FIFO_EN for a FIFO_DEPTH-byte FIFO; otherwise a single holding register.
module avr_uart_tx #(
   parameter int CLK_PER_BIT = 100,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       avr_rx_busy,
   output logic       tx,
   output logic       busy
);

   localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

   if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("avr_uart_tx: illegal CLK_PER_BIT or FIFO_DEPTH");
   end

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg;
   logic          tx_reg, tx_next;
   logic          busy_meta_reg, busy_sync_reg;
   logic          ready_en_reg;
   logic          line_active_reg;
   logic          push, pop, shift_en, stored, bit_end;
   logic [7:0]    head_data;

   assign push    = tx_valid && tx_ready;
   assign bit_end = (baud_reg == '0);

`ifdef AVR_UART_TX_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [7:0]  mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]   count_reg;

   assign stored    = (count_reg != '0);
   assign tx_ready  = ready_en_reg && (count_reg != (PW+1)'(FIFO_DEPTH));
   assign head_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (PW+1)'(1);
            2'b01:   count_reg <= count_reg - (PW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end
`else
   logic [7:0] hold_reg;
   logic       hold_valid_reg;

   assign stored    = hold_valid_reg;
   assign tx_ready  = ready_en_reg && (state_reg == IDLE) && !hold_valid_reg;
   assign head_data = hold_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_reg       <= '0;
         hold_valid_reg <= 1'b0;
      end else if (push) begin
         hold_reg       <= tx_data;
         hold_valid_reg <= 1'b1;
      end else if (pop) begin
         hold_valid_reg <= 1'b0;
      end
   end
`endif

   // Synchronizer resets to "AVR busy" so nothing is sent until the real level is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_meta_reg   <= 1'b1;
         busy_sync_reg   <= 1'b1;
         ready_en_reg    <= 1'b0;
         line_active_reg <= 1'b0;
      end else begin
         busy_meta_reg   <= avr_rx_busy;
         busy_sync_reg   <= busy_meta_reg;
         ready_en_reg    <= 1'b1;
         line_active_reg <= (state_reg != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg - CW'(1);
      bit_next   = bit_reg;
      pop        = 1'b0;
      shift_en   = 1'b0;
      tx_next    = 1'b1;
      case (state_reg)
         IDLE: begin
            baud_next = BIT_LAST;
            bit_next  = 3'd0;
            if (stored && !busy_sync_reg) begin
               state_next = START;
               pop        = 1'b1;
            end
         end
         START: begin
            tx_next = 1'b0;
            if (bit_end) begin
               state_next = DATA;
               baud_next  = BIT_LAST;
            end
         end
         DATA: begin
            tx_next = shift_reg[0];
            if (bit_end) begin
               baud_next = BIT_LAST;
               shift_en  = 1'b1;
               bit_next  = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_next = BIT_LAST;
               if (stored && !busy_sync_reg) begin
                  state_next = START;
                  pop        = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // tx follows the state one cycle late, so every bit still lasts exactly one period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_reg  <= BIT_LAST;
         bit_reg   <= 3'd0;
         shift_reg <= 8'h00;
         tx_reg    <= 1'b1;
      end else begin
         baud_reg <= baud_next;
         bit_reg  <= bit_next;
         tx_reg   <= tx_next;
         if (pop)           shift_reg <= head_data;
         else if (shift_en) shift_reg <= {1'b0, shift_reg[7:1]};
      end
   end

   assign tx   = tx_reg;
   assign busy = (state_reg != IDLE) || line_active_reg || stored;

endmodule

// File: tb/tb_avr_uart_tx.sv
// Randomized scoreboard bench for avr_uart_tx: a serial-line monitor decodes frames
// and compares them against bytes queued at acceptance time.
module tb_avr_uart_tx;
   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       avr_rx_busy;
   logic       tx;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];
   int         mon_cnt = -1;
   int         m_idx;
   logic       m_eb;
   logic       m_have;
   logic       m_shape;
   logic [7:0] m_exp;
   logic [7:0] m_rx;

   avr_uart_tx #(.CLK_PER_BIT(N), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .avr_rx_busy(avr_rx_busy), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end else begin
         $display("[TB] ok %s value=%0h (cycle %0d)", name, act, cyc);
      end
   endtask

   // Serial-line monitor: an ideal 8N1 waveform is derived from the expected byte.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_cnt = -1;
            exp_q.delete();
         end else begin
            if (mon_cnt < 0 && tx == 1'b0) begin
               start_q.push_back(cyc);
               m_shape = 1'b1;
               m_rx    = 8'h00;
               if (exp_q.size() == 0) begin
                  m_have = 1'b0;
                  m_exp  = 8'h00;
                  tests++;
                  fails++;
                  $display("FAIL unexpected_frame actual=start bit required=idle line (cycle %0d)", cyc);
               end else begin
                  m_have = 1'b1;
                  m_exp  = exp_q.pop_front();
               end
               mon_cnt = 0;
            end
            if (mon_cnt >= 0) begin
               m_idx = mon_cnt / N;
               if (m_idx == 0)      m_eb = 1'b0;
               else if (m_idx == 9) m_eb = 1'b1;
               else                 m_eb = m_exp[m_idx-1];
               if (m_have && tx !== m_eb) m_shape = 1'b0;
               if (m_idx >= 1 && m_idx <= 8 && (mon_cnt % N) == N/2) m_rx[m_idx-1] = tx;
               mon_cnt++;
               if (mon_cnt == 10*N) begin
                  mon_cnt = -1;
                  if (m_have) begin
                     check("frame_data", int'(m_rx), int'(m_exp));
                     check("frame_timing", int'(m_shape), 1);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=still running required=finished (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic push(input logic [7:0] b);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         tests++;
         fails++;
         $display("FAIL push_timeout actual=tx_ready low required=accept of %02h", b);
         tx_valid = 1'b0;
      end else begin
         exp_q.push_back(b);
         $display("[TB] push %02h accepted at cycle %0d", b, cyc);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (n < 3000 && !(busy == 1'b0 && mon_cnt < 0 && exp_q.size() == 0)) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", int'(n < 3000), 1);
   endtask

   task automatic wait_start(output int n);
      n = 0;
      while (tx && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", int'(n < 200), 1);
   endtask

   initial begin
      int n;
      int first;
      rst_n       = 1'b0;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      avr_rx_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_ready", int'(tx_ready), 0);
      check("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", int'(tx_ready), 1);
      repeat (3) @(negedge clk);

      // 0x55 from idle: start bit appears on the 2nd edge after acceptance
      push(8'h55);
      tx_valid = 1'b0;
      @(negedge clk);
      check("tx_high_edge1", int'(tx), 1);
      @(negedge clk);
      check("tx_low_edge2", int'(tx), 0);
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 20)) @(negedge clk);
         push(8'($urandom));
         tx_valid = 1'b0;
      end
      wait_idle();

`ifdef AVR_UART_TX_FIFO_EN
      push(8'h3C);
      tx_valid = 1'b0;
      check("ready_during_frame", int'(tx_ready), 1);
      wait_idle();

      // Five back-to-back pushes fill shift register plus four FIFO slots
      start_q.delete();
      for (int b = 1; b <= 5; b++) push(8'(b));
      tx_data = 8'h06;
      check("ready_low_when_full", int'(tx_ready), 0);
      @(negedge clk);
      check("ready_still_low", int'(tx_ready), 0);
      tx_valid = 1'b0;
      wait_idle();
      check("frames_count", start_q.size(), 5);
      for (int i = 1; i < start_q.size(); i++)
         check("frames_contiguous", start_q[i] - start_q[i-1], 10*N);

      // Push lands on the same edge the second byte is popped at STOP exit
      push(8'h10);
      push(8'h11);
      push(8'h12);
      tx_valid = 1'b0;
      wait_start(n);
      repeat (10*N - 2) @(negedge clk);
      push(8'h13);
      push(8'h14);
      push(8'h15);
      check("ready_low_after_same_cycle", int'(tx_ready), 0);
      tx_valid = 1'b0;
      wait_idle();
`else
      push(8'h3C);
      tx_data  = 8'h99;
      n        = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      tx_valid = 1'b0;
      check("ready_low_span", n, 10*N + 1);
      wait_idle();

      for (int b = 1; b <= 5; b++) begin
         push(8'(b));
         tx_valid = 1'b0;
      end
      wait_idle();
`endif

      // Busy from the AVR holds off the frame, then cannot truncate one in flight
      avr_rx_busy = 1'b1;
      repeat (4) @(negedge clk);
      push(8'hA3);
      tx_valid = 1'b0;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (!tx) n++;
      end
      check("busy_blocks_start", n, 0);
      check("busy_out_while_stored", int'(busy), 1);
      avr_rx_busy = 1'b0;
      n = 0;
      while (tx && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("busy_release_edges", n, 4);
      repeat (15) @(negedge clk);
      avr_rx_busy = 1'b1;
      n = 0;
      while (mon_cnt >= 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      avr_rx_busy = 1'b0;
      wait_idle();

      // Reset during data bit 3 of 0xFF with bytes queued behind it
      push(8'hFF);
`ifdef AVR_UART_TX_FIFO_EN
      push(8'hC1);
      push(8'hC2);
`endif
      tx_valid = 1'b0;
      wait_start(n);
      repeat (4*N + 1) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_tx", int'(tx), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_ready", int'(tx_ready), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      repeat (100) begin
         @(negedge clk);
         if (!tx) n++;
      end
      check("no_stale_frame", n, 0);

      // Reset during a start bit must drive tx high without a clock edge
      push(8'h00);
      tx_valid = 1'b0;
      wait_start(n);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_start_tx", int'(tx), 1);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 6)) @(negedge clk);
         push(8'($urandom));
         tx_valid = 1'b0;
      end
      wait_idle();
      first = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails + first);
      $finish;
   end
endmodule
